zmod_dac_spi_config: RTL and testbench

- Power-up and runtime configuration sequencer for the ZMOD AD9717 dual DAC. It replaces the fixed pin-mode straps with SPI register programming.
- Drives the DAC reset pin, then issues a parameterised table of 16-bit SPI register writes.
- Then accepts further register writes from a valid/ready command port.
- Asserts init_done, which the top level uses to gate s_axis_tvalid into the DAC datapath.

---
 rtl/zmod_dac_spi_config.sv | 179 +++++++++++++++++
 tb/tb_zmod_dac_spi_config.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zmod_dac_spi_config.sv
// AD9717 configuration sequencer: drives the DAC reset pin, streams an
// init table of 16-bit SPI writes, then serves runtime writes.
module zmod_dac_spi_config #(
  parameter int          CLK_DIV         = 4,
  parameter int          RST_CYCLES      = 16,
  parameter int          POST_RST_CYCLES = 64,
  parameter int          N_WRITES        = 4,
  parameter logic [255:0] INIT_TABLE     = '0
) (
  input  logic        aclk,
  input  logic        resetn,
  input  logic [15:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        rst_spi,
  output logic        spi_sck,
  output logic        spi_cs,
  output logic        spi_sdo,
  output logic        busy,
  output logic        init_done
);

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_IDLE
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] C_RST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] C_POST = CW'(POST_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_GAP  = CW'(2 * CLK_DIV - 1);
  localparam logic [4:0]    C_LAST = 5'(N_WRITES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [3:0]    r_idx;
  logic [15:0]   r_shift;
  logic [15:0]   r_cmd;
  logic          r_rst;
  logic          r_sck;
  logic          r_cs;
  logic          r_sdo;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;

  logic [15:0]   w_entry;
  logic [15:0]   w_next;
  logic          w_more;

  // Word source: table entry during init, captured command afterwards.
  always_comb begin
    w_entry = INIT_TABLE[{r_idx, 4'b0000} +: 16];
    w_next  = r_done ? r_cmd : w_entry;
    w_more  = ({1'b0, r_idx} < C_LAST);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_RST;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_cmd   <= '0;
      r_rst   <= 1'b1;
      r_sck   <= 1'b0;
      r_cs    <= 1'b1;
      r_sdo   <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_RST: begin
          if (r_cnt == C_RST) begin
            r_cnt   <= '0;
            r_rst   <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (r_cnt == C_POST) begin
            r_cnt <= '0;
            if (N_WRITES == 0) begin
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              // First CS assertion lands exactly on the end of the idle time.
              r_idx   <= '0;
              r_shift <= INIT_TABLE[15:0];
              r_sdo   <= INIT_TABLE[15];
              r_cs    <= 1'b0;
              r_bit   <= '0;
              r_state <= S_SHIFT;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_LOAD: begin
          r_shift <= w_next;
          r_sdo   <= w_next[15];
          r_cs    <= 1'b0;
          r_bit   <= '0;
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
            end else if (r_bit == 4'd15) begin
              r_sck   <= 1'b0;
              r_cs    <= 1'b1;
              r_sdo   <= 1'b0;
              r_state <= S_GAP;
            end else begin
              r_sck   <= 1'b0;
              r_shift <= {r_shift[14:0], 1'b0};
              r_sdo   <= r_shift[14];
              r_bit   <= r_bit + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == C_GAP) begin
            r_cnt <= '0;
            if (!r_done && w_more) begin
              r_idx   <= r_idx + 4'd1;
              r_state <= S_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (cmd_valid && r_ready) begin
            r_cmd   <= cmd_data;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        default: begin
          r_state <= S_RST;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign rst_spi   = r_rst;
  assign spi_sck   = r_sck;
  assign spi_cs    = r_cs;
  assign spi_sdo   = r_sdo;
  assign busy      = r_busy;
  assign init_done = r_done;

endmodule

// File: tb/tb_zmod_dac_spi_config.sv
// Directed bench for zmod_dac_spi_config: three parameter sets
// sharing one clock, one active at a time, others held in reset.
module tb_zmod_dac_spi_config;

  logic        aclk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  sel  = 2'd0;
  logic [15:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;

  logic [2:0] rn;
  logic [2:0] o_ready, o_rst, o_sck, o_cs, o_sdo, o_busy, o_done;
  logic w_ready, w_rst, w_sck, w_cs, w_sdo, w_busy, w_done;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  assign rn[0] = rstn && (sel == 2'd0);
  assign rn[1] = rstn && (sel == 2'd1);
  assign rn[2] = rstn && (sel == 2'd2);

  zmod_dac_spi_config #(
    .CLK_DIV(2), .RST_CYCLES(4), .POST_RST_CYCLES(8), .N_WRITES(2),
    .INIT_TABLE(256'h0214_0080)
  ) u_a (
    .aclk(aclk), .resetn(rn[0]), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(o_ready[0]), .rst_spi(o_rst[0]),
    .spi_sck(o_sck[0]), .spi_cs(o_cs[0]), .spi_sdo(o_sdo[0]),
    .busy(o_busy[0]), .init_done(o_done[0])
  );

  zmod_dac_spi_config #(
    .CLK_DIV(2), .RST_CYCLES(4), .POST_RST_CYCLES(8), .N_WRITES(0),
    .INIT_TABLE(256'h0)
  ) u_b (
    .aclk(aclk), .resetn(rn[1]), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(o_ready[1]), .rst_spi(o_rst[1]),
    .spi_sck(o_sck[1]), .spi_cs(o_cs[1]), .spi_sdo(o_sdo[1]),
    .busy(o_busy[1]), .init_done(o_done[1])
  );

  zmod_dac_spi_config #(
    .CLK_DIV(1), .RST_CYCLES(4), .POST_RST_CYCLES(8), .N_WRITES(1),
    .INIT_TABLE(256'hFFFF)
  ) u_c (
    .aclk(aclk), .resetn(rn[2]), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(o_ready[2]), .rst_spi(o_rst[2]),
    .spi_sck(o_sck[2]), .spi_cs(o_cs[2]), .spi_sdo(o_sdo[2]),
    .busy(o_busy[2]), .init_done(o_done[2])
  );

  always_comb begin
    w_ready = o_ready[0]; w_rst = o_rst[0]; w_sck = o_sck[0];
    w_cs = o_cs[0]; w_sdo = o_sdo[0]; w_busy = o_busy[0];
    w_done = o_done[0];
    if (sel == 2'd1) begin
      w_ready = o_ready[1]; w_rst = o_rst[1]; w_sck = o_sck[1];
      w_cs = o_cs[1]; w_sdo = o_sdo[1]; w_busy = o_busy[1];
      w_done = o_done[1];
    end else if (sel == 2'd2) begin
      w_ready = o_ready[2]; w_rst = o_rst[2]; w_sck = o_sck[2];
      w_cs = o_cs[2]; w_sdo = o_sdo[2]; w_busy = o_busy[2];
      w_done = o_done[2];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic pick(input int w);
    case (w)
      0: return w_rst;
      1: return w_cs;
      2: return w_done;
      default: return w_ready;
    endcase
  endfunction

  // Count clock edges until the chosen output reaches lvl (bounded).
  task automatic wait_for(input int w, input logic lvl, input int lim,
                          output int n);
    n = 0;
    while (pick(w) !== lvl && n < lim) begin
      tick();
      n++;
    end
  endtask

  // Decode one frame starting from the first CS-low sample.
  task automatic get_frame(input int lim, output logic [15:0] w,
                           output int rises, output int len,
                           output int tog, output bit ones,
                           output bit bsy);
    logic prev;
    w = '0; rises = 0; len = 0; tog = 0; ones = 1'b1; bsy = 1'b1;
    prev = w_sck;
    while (w_cs === 1'b0 && len < lim) begin
      if (w_sdo !== 1'b1) ones = 1'b0;
      if (w_busy !== 1'b1) bsy = 1'b0;
      tick();
      len++;
      if (w_sck !== prev) tog++;
      if (prev === 1'b0 && w_sck === 1'b1) begin
        w = {w[14:0], w_sdo};
        rises++;
      end
      prev = w_sck;
    end
  endtask

  task automatic release_rst();
    @(negedge aclk);
    rstn = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic [15:0] fw;
    int fr, fl, ft;
    bit fo, fb, acc, csl;

    // ---- instance A: reset values ----
    sel = 2'd0;
    rstn = 1'b0;
    repeat (3) tick();
    check("rst_rst_spi", 32'(w_rst), 32'd1);
    check("rst_cs", 32'(w_cs), 32'd1);
    check("rst_sck", 32'(w_sck), 32'd0);
    check("rst_sdo", 32'(w_sdo), 32'd0);
    check("rst_ready", 32'(w_ready), 32'd0);
    check("rst_done", 32'(w_done), 32'd0);
    check("rst_busy", 32'(w_busy), 32'd1);

    // ---- init sequence ----
    release_rst();
    wait_for(0, 1'b0, 100, n);
    check("a_rst_len", 32'(n), 32'd4);
    wait_for(1, 1'b0, 100, n);
    check("a_cs_delay", 32'(n), 32'd8);
    get_frame(200, fw, fr, fl, ft, fo, fb);
    check("a_f0_word", 32'(fw), 32'h0080);
    check("a_f0_rises", 32'(fr), 32'd16);
    check("a_f0_len", 32'(fl), 32'd64);
    check("a_f0_sck_idle", 32'(w_sck), 32'd0);
    check("a_f0_done_lo", 32'(w_done), 32'd0);
    wait_for(1, 1'b0, 100, n);
    check("a_gap_ge4", 32'(n >= 4), 32'd1);
    get_frame(200, fw, fr, fl, ft, fo, fb);
    check("a_f1_word", 32'(fw), 32'h0214);
    check("a_f1_rises", 32'(fr), 32'd16);
    check("a_f1_len", 32'(fl), 32'd64);
    wait_for(2, 1'b1, 100, n);
    check("a_done_delay", 32'(n), 32'd4);
    check("a_idle_ready", 32'(w_ready), 32'd1);
    check("a_idle_busy", 32'(w_busy), 32'd0);

    // ---- single runtime command ----
    cmd_data = 16'h0A5C;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("cmd_ready_drop", 32'(w_ready), 32'd0);
    check("cmd_busy_up", 32'(w_busy), 32'd1);
    wait_for(1, 1'b0, 100, n);
    check("cmd_cs_lat", 32'(n), 32'd1);
    get_frame(200, fw, fr, fl, ft, fo, fb);
    check("cmd_word", 32'(fw), 32'h0A5C);
    check("cmd_len", 32'(fl), 32'd64);
    check("cmd_busy_frame", 32'(fb), 32'd1);
    wait_for(3, 1'b1, 100, n);
    check("cmd_ready_back", 32'(n), 32'd4);

    // ---- back-to-back commands, valid held high ----
    cmd_data = 16'h0100;
    cmd_valid = 1'b1;
    tick();
    cmd_data = 16'h0300;
    wait_for(1, 1'b0, 100, n);
    get_frame(200, fw, fr, fl, ft, fo, fb);
    check("b2b_w0", 32'(fw), 32'h0100);
    check("b2b_r0", 32'(fr), 32'd16);
    n = 0;
    while (w_cs !== 1'b0 && n < 200) begin
      acc = (w_ready === 1'b1) && cmd_valid;
      tick();
      n++;
      if (acc) cmd_valid = 1'b0;
    end
    check("b2b_gap_ge4", 32'(n >= 4), 32'd1);
    check("b2b_ready_in_frame", 32'(w_ready), 32'd0);
    get_frame(200, fw, fr, fl, ft, fo, fb);
    check("b2b_w1", 32'(fw), 32'h0300);
    check("b2b_len1", 32'(fl), 32'd64);
    wait_for(3, 1'b1, 100, n);
    check("b2b_ready_back", 32'(n), 32'd4);
    check("b2b_valid_dropped", 32'(cmd_valid), 32'd0);
    repeat (10) tick();
    check("b2b_no_extra", 32'(w_cs), 32'd1);

    // ---- reset pulsed at bit 7 of the first frame ----
    rstn = 1'b0;
    repeat (2) tick();
    release_rst();
    wait_for(0, 1'b0, 100, n);
    wait_for(1, 1'b0, 100, n);
    repeat (29) tick();
    check("mid_cs_low", 32'(w_cs), 32'd0);
    rstn = 1'b0;
    #1;
    check("mid_cs", 32'(w_cs), 32'd1);
    check("mid_sck", 32'(w_sck), 32'd0);
    check("mid_rst_spi", 32'(w_rst), 32'd1);
    check("mid_done", 32'(w_done), 32'd0);
    check("mid_sdo", 32'(w_sdo), 32'd0);
    repeat (3) tick();
    release_rst();
    wait_for(0, 1'b0, 100, n);
    check("re_rst_len", 32'(n), 32'd4);
    wait_for(1, 1'b0, 100, n);
    check("re_cs_delay", 32'(n), 32'd8);
    get_frame(200, fw, fr, fl, ft, fo, fb);
    check("re_f0_word", 32'(fw), 32'h0080);
    check("re_f0_len", 32'(fl), 32'd64);
    wait_for(1, 1'b0, 100, n);
    get_frame(200, fw, fr, fl, ft, fo, fb);
    check("re_f1_word", 32'(fw), 32'h0214);

    // ---- instance B: empty init table ----
    sel = 2'd1;
    rstn = 1'b0;
    repeat (3) tick();
    release_rst();
    wait_for(0, 1'b0, 100, n);
    check("b_rst_len", 32'(n), 32'd4);
    n = 0;
    csl = 1'b0;
    while (w_done !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (w_cs !== 1'b1) csl = 1'b1;
    end
    check("b_done_delay", 32'(n), 32'd8);
    check("b_cs_quiet", 32'(csl), 32'd0);
    check("b_ready", 32'(w_ready), 32'd1);
    repeat (20) begin
      tick();
      if (w_cs !== 1'b1) csl = 1'b1;
    end
    check("b_cs_still_quiet", 32'(csl), 32'd0);

    // ---- instance C: CLK_DIV=1, all-ones word ----
    sel = 2'd2;
    rstn = 1'b0;
    repeat (3) tick();
    release_rst();
    wait_for(0, 1'b0, 100, n);
    check("c_rst_len", 32'(n), 32'd4);
    wait_for(1, 1'b0, 100, n);
    check("c_cs_delay", 32'(n), 32'd8);
    get_frame(100, fw, fr, fl, ft, fo, fb);
    check("c_word", 32'(fw), 32'hFFFF);
    check("c_len", 32'(fl), 32'd32);
    check("c_toggles", 32'(ft), 32'd32);
    check("c_sdo_ones", 32'(fo), 32'd1);
    check("c_rises", 32'(fr), 32'd16);
    wait_for(2, 1'b1, 100, n);
    check("c_done_delay", 32'(n), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
